// File: rtl/agen_slot_pkg.sv
// Shared types for the AGEN issue slot and its helpers.
// Access sizes, queue id, writeback bundle, FSM states, alignment masks.
package agen_slot_pkg;

  localparam int AGEN_IQ   = 8;
  localparam int AGEN_QIDW = $clog2(AGEN_IQ);
  localparam int AGEN_AWID = 52;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } AgenSize;

  typedef logic [AGEN_QIDW-1:0] Qid;

  typedef struct packed {
    Qid                   qid;
    logic [AGEN_AWID-1:0] addr;
    logic                 fault;
  } agen_wb_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WB   = 2'd2
  } agen_state_e;

  // Low address bits that must be zero for an aligned access.
  function automatic logic [2:0] align_mask(AgenSize sz);
    logic [2:0] m;
    m = 3'b000;
    unique case (sz)
      SZ_BYTE:  m = 3'b000;
      SZ_HALF:  m = 3'b001;
      SZ_WORD:  m = 3'b011;
      SZ_DWORD: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/agen_slot_onehot_enc.sv
// One-hot to binary index encoder with a one-hot validity flag.
// Shared by issue-consuming slots (agen, alu, fpu).
module onehot_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         onehot_ok_o
);

  // OR together the indices of all set bits; exact when one-hot.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = idx_o | W'(i);
    end
  end

  assign onehot_ok_o = (vec_i != '0) &&
                       ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/agen_slot.sv
// AGEN issue slot: accepts one IQ entry, computes base+(index<<scale)+disp,
// and returns it with its queue id on a req/ack writeback handshake.
module agen_slot
  import agen_slot_pkg::*;
#(
  parameter int IQ_ENTRIES = 8,
  parameter int QIDW       = $clog2(IQ_ENTRIES),
  parameter int AWID       = 52,
  parameter int AGEN_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [IQ_ENTRIES-1:0] issue_i,
  input  logic [AWID-1:0]       base_i,
  input  logic [AWID-1:0]       index_i,
  input  logic [AWID-1:0]       disp_i,
  input  logic [1:0]            scale_i,
  input  logic [1:0]            size_i,
  input  logic [IQ_ENTRIES-1:0] kill_i,
  output logic                  idle_o,
  output logic                  wb_req_o,
  input  logic                  wb_ack_i,
  output logic [QIDW-1:0]       wb_qid_o,
  output logic [AWID-1:0]       wb_addr_o,
  output logic                  wb_fault_o,
  output logic                  err_o
);

  localparam logic [1:0] CNT_INIT = 2'(AGEN_LAT - 1);

  agen_state_e       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [QIDW-1:0]   qid_q, qid_d;
  logic [AWID-1:0]   base_q, base_d;
  logic [AWID-1:0]   index_q, index_d;
  logic [AWID-1:0]   disp_q, disp_d;
  logic [1:0]        scale_q, scale_d;
  AgenSize           size_q, size_d;
  logic              req_q, req_d;
  logic [QIDW-1:0]   wqid_q, wqid_d;
  logic [AWID-1:0]   waddr_q, waddr_d;
  logic              wfault_q, wfault_d;
  logic              err_q, err_d;

  logic [QIDW-1:0]   enc_idx;
  logic              enc_ok;
  logic              is_idle;
  logic              issue_any;
  logic              accept;
  logic              kill_hit;

  logic [AWID-1:0]   src_base;
  logic [AWID-1:0]   src_index;
  logic [AWID-1:0]   src_disp;
  logic [1:0]        src_scale;
  AgenSize           src_size;
  logic [QIDW-1:0]   src_qid;
  logic [AWID-1:0]   sum;
  logic              misal;

  onehot_enc #(
    .N (IQ_ENTRIES),
    .W (QIDW)
  ) u_enc (
    .vec_i       (issue_i),
    .idx_o       (enc_idx),
    .onehot_ok_o (enc_ok)
  );

  assign is_idle   = (state_q == ST_IDLE);
  assign issue_any = |issue_i;
  assign accept    = is_idle && enc_ok && !kill_i[enc_idx];
  assign kill_hit  = kill_i[qid_q];
  assign idle_o    = is_idle && !issue_any;

  // Operands come straight from the issue bus when loading from IDLE
  // (single-cycle latency), otherwise from the latched copy.
  always_comb begin
    src_base  = is_idle ? base_i  : base_q;
    src_index = is_idle ? index_i : index_q;
    src_disp  = is_idle ? disp_i  : disp_q;
    src_scale = is_idle ? scale_i : scale_q;
    src_size  = is_idle ? AgenSize'(size_i) : size_q;
    src_qid   = is_idle ? enc_idx : qid_q;
    sum       = src_base + (src_index << src_scale) + src_disp;
    misal     = |(sum[2:0] & align_mask(src_size));
  end

  // Next-state logic: issue accept, latency countdown, writeback, kill.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qid_d    = qid_q;
    base_d   = base_q;
    index_d  = index_q;
    disp_d   = disp_q;
    scale_d  = scale_q;
    size_d   = size_q;
    req_d    = req_q;
    wqid_d   = wqid_q;
    waddr_d  = waddr_q;
    wfault_d = wfault_q;
    err_d    = 1'b0;
    if (ce) begin
      err_d = issue_any && (!is_idle || !enc_ok);
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            qid_d   = enc_idx;
            base_d  = base_i;
            index_d = index_i;
            disp_d  = disp_i;
            scale_d = scale_i;
            size_d  = AgenSize'(size_i);
            cnt_d   = CNT_INIT;
            if (AGEN_LAT == 1) begin
              state_d  = ST_WB;
              req_d    = 1'b1;
              wqid_d   = src_qid;
              waddr_d  = sum;
              wfault_d = misal;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (kill_hit) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
              state_d  = ST_WB;
              req_d    = 1'b1;
              wqid_d   = src_qid;
              waddr_d  = sum;
              wfault_d = misal;
            end
          end
        end
        ST_WB: begin
          if (wb_ack_i || kill_hit) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      qid_q    <= '0;
      base_q   <= '0;
      index_q  <= '0;
      disp_q   <= '0;
      scale_q  <= '0;
      size_q   <= SZ_BYTE;
      req_q    <= 1'b0;
      wqid_q   <= '0;
      waddr_q  <= '0;
      wfault_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qid_q    <= qid_d;
      base_q   <= base_d;
      index_q  <= index_d;
      disp_q   <= disp_d;
      scale_q  <= scale_d;
      size_q   <= size_d;
      req_q    <= req_d;
      wqid_q   <= wqid_d;
      waddr_q  <= waddr_d;
      wfault_q <= wfault_d;
      err_q    <= err_d;
    end
  end

  assign wb_req_o   = req_q;
  assign wb_qid_o   = wqid_q;
  assign wb_addr_o  = waddr_q;
  assign wb_fault_o = wfault_q;
  assign err_o      = err_q;

endmodule
